agc_measure_ctrl: RTL and testbench

Sequencer and capture stage that sits directly downstream of the per-channel AGC core.
- Drives the core's agc_tick/agc_ce pair to run one fixed-length measurement period.
- Waits out the accumulator pipeline, then latches the square and probit accumulator results into holding registers.
- Presents the held results to the register/loop-calculation side with a valid/ack handshake and a sticky overrun flag.

---
 rtl/agc_pkg.sv | 25 ++
 rtl/agc_period_counter.sv | 28 ++
 rtl/agc_measure_ctrl.sv | 136 +++++++++++++
 tb/tb_agc_measure_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// Shared AGC definitions: measurement sequencer states and default core widths.
// Imported by the measurement controller and by the AGC core instantiation.
package agc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TICK,
        RUN,
        DRAIN,
        CAPT
    } agc_state_e;

    localparam int AGC_SQ_BITS     = 25;
    localparam int AGC_PR_BITS     = 21;
    localparam int AGC_PERIOD      = 131072;
    localparam int AGC_ACC_LATENCY = 3;

    // One counter serves both the measurement period and the drain wait.
    function automatic int agc_cnt_width(input int period, input int latency);
        int m;
        m = (period > latency) ? period : latency;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/agc_period_counter.sv
// Loadable down-counter with terminal-count flag; times RUN and DRAIN phases.
// Load has priority over decrement and the count saturates at zero.
module agc_period_counter #(
    parameter int W = 17
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/agc_measure_ctrl.sv
// Runs one AGC measurement period (tick, enable, drain), captures accumulator
// results into holding registers and hands them off with valid/ack + overrun.
module agc_measure_ctrl
    import agc_pkg::*;
#(
    parameter int SQ_BITS     = AGC_SQ_BITS,
    parameter int PR_BITS     = AGC_PR_BITS,
    parameter int PERIOD      = AGC_PERIOD,
    parameter int ACC_LATENCY = AGC_ACC_LATENCY
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               continuous_i,
    output logic               agc_tick_o,
    output logic               agc_ce_o,
    input  logic [SQ_BITS-1:0] sq_accum_i,
    input  logic [PR_BITS-1:0] gt_accum_i,
    input  logic [PR_BITS-1:0] lt_accum_i,
    output logic [SQ_BITS-1:0] sq_o,
    output logic [PR_BITS-1:0] gt_o,
    output logic [PR_BITS-1:0] lt_o,
    output logic               valid_o,
    input  logic               ack_i,
    output logic               done_o,
    output logic               busy_o,
    output logic               overrun_o
);

    localparam int CNT_W = agc_cnt_width(PERIOD, ACC_LATENCY);

    agc_state_e       state;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_val;

    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state)
            TICK: begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(PERIOD - 1);
            end
            RUN: begin
                if (cnt_tc) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(ACC_LATENCY - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DRAIN:   cnt_dec = ~cnt_tc;
            default: ;
        endcase
    end

    agc_period_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (cnt_load),
        .load_val(cnt_val),
        .dec     (cnt_dec),
        .tc      (cnt_tc)
    );

    // Outputs are set on the edge that enters the state they belong to,
    // so each one is a plain register with no input-to-output path.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            agc_tick_o <= 1'b0;
            agc_ce_o   <= 1'b0;
            sq_o       <= '0;
            gt_o       <= '0;
            lt_o       <= '0;
            valid_o    <= 1'b0;
            done_o     <= 1'b0;
            busy_o     <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            agc_tick_o <= 1'b0;
            agc_ce_o   <= 1'b0;
            done_o     <= 1'b0;
            if (ack_i) begin
                valid_o   <= 1'b0;
                overrun_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_i || continuous_i) begin
                        state      <= TICK;
                        agc_tick_o <= 1'b1;
                        busy_o     <= 1'b1;
                    end
                end
                TICK: begin
                    state    <= RUN;
                    agc_ce_o <= 1'b1;
                end
                RUN: begin
                    if (cnt_tc) state <= DRAIN;
                    else        agc_ce_o <= 1'b1;
                end
                DRAIN: begin
                    if (cnt_tc) state <= CAPT;
                end
                CAPT: begin
                    sq_o    <= sq_accum_i;
                    gt_o    <= gt_accum_i;
                    lt_o    <= lt_accum_i;
                    valid_o <= 1'b1;
                    done_o  <= 1'b1;
                    // A same-cycle ack consumes the old result, so no overrun.
                    overrun_o <= (valid_o | overrun_o) & ~ack_i;
                    if (continuous_i) begin
                        state      <= TICK;
                        agc_tick_o <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_agc_measure_ctrl.sv
// Randomised bench for agc_measure_ctrl against a timeline model of one
// measurement (tick/enable/capture cycles derived from the start cycle).
module tb_agc_measure_ctrl;

    localparam int P  = 16;
    localparam int A  = 3;
    localparam int P2 = 2;
    localparam int A2 = 1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0, continuous_i = 1'b0, ack_i = 1'b0;
    logic [24:0] sq_accum = '0;
    logic [20:0] gt_accum = '0, lt_accum = '0;
    logic        agc_tick_o, agc_ce_o, valid_o, done_o, busy_o, overrun_o;
    logic [24:0] sq_o;
    logic [20:0] gt_o, lt_o;

    logic        start2 = 1'b0;
    logic        tick2, ce2, valid2, done2, busy2, over2;
    logic [24:0] sq2;
    logic [20:0] gt2, lt2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    agc_measure_ctrl #(.SQ_BITS(25), .PR_BITS(21), .PERIOD(P), .ACC_LATENCY(A)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .continuous_i(continuous_i),
        .agc_tick_o(agc_tick_o), .agc_ce_o(agc_ce_o),
        .sq_accum_i(sq_accum), .gt_accum_i(gt_accum), .lt_accum_i(lt_accum),
        .sq_o(sq_o), .gt_o(gt_o), .lt_o(lt_o), .valid_o(valid_o), .ack_i(ack_i),
        .done_o(done_o), .busy_o(busy_o), .overrun_o(overrun_o));

    agc_measure_ctrl #(.SQ_BITS(25), .PR_BITS(21), .PERIOD(P2), .ACC_LATENCY(A2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start2), .continuous_i(1'b0),
        .agc_tick_o(tick2), .agc_ce_o(ce2),
        .sq_accum_i(sq_accum), .gt_accum_i(gt_accum), .lt_accum_i(lt_accum),
        .sq_o(sq2), .gt_o(gt2), .lt_o(lt2), .valid_o(valid2), .ack_i(1'b0),
        .done_o(done2), .busy_o(busy2), .overrun_o(over2));

    // Model: s is the cycle in which the current run's start was seen (-1 idle).
    int          cyc = 0;
    int          s = -1;
    logic        m_valid = 0, m_over = 0, m_done = 0;
    logic [24:0] m_sq = '0;
    logic [20:0] m_gt = '0, m_lt = '0;

    function automatic logic [72:0] exp_vec();
        logic tk, ce, bz;
        tk = (s >= 0) && (cyc == s + 1);
        ce = (s >= 0) && (cyc >= s + 2) && (cyc <= s + 1 + P);
        bz = (s >= 0);
        return {tk, ce, bz, m_valid, m_done, m_over, m_sq, m_gt, m_lt};
    endfunction

    function automatic logic [72:0] dut_vec();
        return {agc_tick_o, agc_ce_o, busy_o, valid_o, done_o, overrun_o, sq_o, gt_o, lt_o};
    endfunction

    task automatic step();
        logic p_start, p_cont, p_ack, p_rst, cap;
        logic [24:0] p_sq;
        logic [20:0] p_gt, p_lt;
        p_start = start_i; p_cont = continuous_i; p_ack = ack_i; p_rst = rst_i;
        p_sq = sq_accum; p_gt = gt_accum; p_lt = lt_accum;
        @(posedge clk_i);
        cyc++;
        if (p_rst) begin
            s = -1; m_valid = 0; m_over = 0; m_done = 0; m_sq = '0; m_gt = '0; m_lt = '0;
        end else begin
            cap = (s >= 0) && (cyc == s + 3 + P + A);
            m_done = cap;
            if (cap) begin
                m_sq = p_sq; m_gt = p_gt; m_lt = p_lt;
                m_over = p_ack ? 1'b0 : (m_valid | m_over);
                m_valid = 1'b1;
                s = p_cont ? cyc - 1 : -1;
            end else begin
                if (s < 0 && (p_start || p_cont)) s = cyc - 1;
                if (p_ack) begin m_valid = 0; m_over = 0; end
            end
        end
        #1;
    endtask

    task automatic randomize_data();
        sq_accum = 25'($urandom);
        gt_accum = 21'($urandom);
        lt_accum = 21'($urandom);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (5) begin
            if (cyc == 2) rst_i = 1'b0;
            step();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single();
        int s0, ticks, ces;
        ticks = 0; ces = 0;
        sq_accum = 25'h123456; gt_accum = 21'h1ABCD; lt_accum = 21'h0F00;
        start_i = 1'b1; s0 = cyc;
        while (cyc < s0 + 5 + P + A) begin
            step();
            start_i = (cyc == s0 + 8);
            ticks += int'(agc_tick_o);
            ces += int'(agc_ce_o);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL single cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (cyc == s0 + 3 + P + A) begin
                vectors++;
                if ({valid_o, done_o, sq_o, gt_o, lt_o} !== {2'b11, 25'h123456, 21'h1ABCD, 21'h0F00}) begin
                    miscompares++;
                    $display("FAIL single_capture got v=%b d=%b sq=%h gt=%h lt=%h", valid_o, done_o, sq_o, gt_o, lt_o);
                end
            end
        end
        vectors++;
        if (ticks != 1 || ces != P || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL single_counts ticks=%0d ces=%0d busy=%b exp 1/%0d/0", ticks, ces, busy_o, P);
        end
    endtask

    task automatic test_continuous();
        int dones;
        logic [24:0] prev_sq;
        dones = 0;
        ack_i = 1'b1; step(); ack_i = 1'b0;
        continuous_i = 1'b1;
        for (int n = 0; n < 3 * (P + A + 2) + 4 && dones < 2; n++) begin
            randomize_data();
            prev_sq = sq_accum;
            step();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL continuous cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (done_o === 1'b1) begin
                dones++;
                vectors++;
                if (sq_o !== prev_sq || overrun_o !== (dones == 2) || agc_tick_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL continuous_capture sq=%h exp %h over=%b tick=%b", sq_o, prev_sq, overrun_o, agc_tick_o);
                end
            end
        end
        vectors++;
        if (dones != 2) begin
            miscompares++;
            $display("FAIL continuous_timeout dones=%0d exp 2", dones);
        end
        continuous_i = 1'b0;
        for (int n = 0; n < 2 * (P + A + 3) && busy_o !== 1'b0; n++) step();
        ack_i = 1'b1; step(); ack_i = 1'b0;
        vectors++;
        if ({busy_o, valid_o, overrun_o} !== 3'b000 || dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL continuous_ack busy=%b valid=%b over=%b exp 000", busy_o, valid_o, overrun_o);
        end
    endtask

    task automatic test_ack_on_capture();
        int s1;
        for (int r = 0; r < 2; r++) begin
            randomize_data();
            start_i = 1'b1; s1 = cyc;
            while (cyc < s1 + 3 + P + A) begin
                ack_i = (r == 1) && (cyc == s1 + 2 + P + A);
                step();
                start_i = 1'b0;
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL ack_capture cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
                end
            end
            ack_i = 1'b0;
        end
        vectors++;
        if ({valid_o, overrun_o, done_o} !== 3'b101) begin
            miscompares++;
            $display("FAIL ack_capture_flags valid=%b over=%b done=%b exp 1 0 1", valid_o, overrun_o, done_o);
        end
    endtask

    task automatic test_reset_mid_run();
        int s0;
        randomize_data();
        start_i = 1'b1; s0 = cyc;
        while (cyc < s0 + 6) begin step(); start_i = 1'b0; end
        rst_i = 1'b1; step(); rst_i = 1'b0;
        vectors++;
        if ({agc_ce_o, busy_o, valid_o, sq_o, gt_o, lt_o} !== '0 || dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_mid ce=%b busy=%b valid=%b sq=%h gt=%h lt=%h exp all 0",
                     agc_ce_o, busy_o, valid_o, sq_o, gt_o, lt_o);
        end
        repeat (P + A + 6) begin
            step();
            vectors++;
            if (done_o !== 1'b0 || dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_mid_idle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        start_i = 1'b1; s0 = cyc;
        while (cyc < s0 + 3 + P + A) begin
            step();
            start_i = 1'b0;
            vectors++;
            if (dut_vec() !== exp_vec() || (cyc == s0 + 1 && agc_tick_o !== 1'b1)) begin
                miscompares++;
                $display("FAIL reset_mid_rerun cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        repeat (900) begin
            start_i = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) continuous_i = ~continuous_i;
            ack_i = ($urandom_range(0, 7) == 0);
            rst_i = ($urandom_range(0, 299) == 0);
            randomize_data();
            step();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        start_i = 1'b0; continuous_i = 1'b0; ack_i = 1'b0; rst_i = 1'b0;
    endtask

    task automatic test_short();
        logic [3:0]  e;
        logic [24:0] dsq;
        logic [20:0] dgt, dlt;
        randomize_data();
        dsq = sq_accum; dgt = gt_accum; dlt = lt_accum;
        start2 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            start2 = 1'b0;
            e = {k == 1, k == 2 || k == 3, k <= 3 + P2 + A2 - 1, k == 3 + P2 + A2};
            vectors++;
            if ({tick2, ce2, busy2, done2} !== e) begin
                miscompares++;
                $display("FAIL short k=%0d tick/ce/busy/done got=%b exp=%b", k, {tick2, ce2, busy2, done2}, e);
            end
        end
        vectors++;
        if ({valid2, over2, sq2, gt2, lt2} !== {2'b10, dsq, dgt, dlt}) begin
            miscompares++;
            $display("FAIL short_capture valid=%b over=%b sq=%h gt=%h lt=%h exp 1 0 %h %h %h",
                     valid2, over2, sq2, gt2, lt2, dsq, dgt, dlt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_ack_on_capture();
        test_reset_mid_run();
        test_random();
        repeat (2 * (P + A + 4)) step();
        test_short();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
